// File: rtl/pc_fetch_unit.sv
// Program-counter unit: fetch PC generation, redirect selection and a
// DEPTH-deep history of in-flight PCs/valid bits up to the branch-resolve stage.
module pc_fetch_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0040001c,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h80000180,
  parameter int               DEPTH      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [15:0]      br_imm16,
  input  logic             jmp,
  input  logic [25:0]      jmp_target26,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_addr,
  output logic [WIDTH-1:0] pc,
  output logic [DEPTH-1:0] hist_vec_valid,
  output logic [WIDTH-1:0] hist_pc,
  output logic [WIDTH-1:0] link_pc,
  output logic [WIDTH-1:0] epc,
  output logic             exc
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  // Word offset sign-extended to WIDTH and scaled to bytes.
  function automatic logic signed [WIDTH-1:0] br_offset(input logic [15:0] imm);
    logic signed [WIDTH-1:0] off;
    off = {{(WIDTH-18){imm[15]}}, imm, 2'b00};
    return off;
  endfunction

  function automatic logic [WIDTH-1:0] jmp_dest(input logic [WIDTH-1:0] link,
                                                input logic [25:0]      idx);
    return {link[WIDTH-1:28], idx, 2'b00};
  endfunction

  logic [WIDTH-1:0] hist [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic             eb;
  logic             ej;
  logic             ejp;
  logic             misalign;

  // A request only counts when the slot it came from is still on the right path.
  assign eb       = br_taken & vld[DEPTH-1];
  assign ej       = jr & vld[0];
  assign ejp      = jmp & vld[0];
  assign misalign = ej & (|jr_addr[1:0]) & ~eb;

  assign link_pc        = hist[0] + PC_STEP;
  assign hist_pc        = hist[DEPTH-1];
  assign hist_vec_valid = vld;

  always_comb begin
    pc_nxt = pc + PC_STEP;
    if (eb)
      pc_nxt = hist[DEPTH-1] + PC_STEP + br_offset(br_imm16);
    else if (misalign)
      pc_nxt = EXC_VECTOR;
    else if (ej)
      pc_nxt = jr_addr;
    else if (ejp)
      pc_nxt = jmp_dest(link_pc, jmp_target26);
  end

  always_comb begin
    vld_nxt = {vld[DEPTH-2:0], 1'b1};
    if (eb)
      vld_nxt = '0;
    else if (ej || ejp)
      vld_nxt[0] = 1'b0;
  end

  // Stage boundary: all state advances on the falling clock edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      pc  <= RESET_PC;
      vld <= '0;
      epc <= '0;
      exc <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        hist[i] <= '0;
    end else begin
      exc <= ~stall & misalign;
      if (!stall) begin
        pc      <= pc_nxt;
        vld     <= vld_nxt;
        hist[0] <= pc;
        for (int i = 1; i < DEPTH; i++)
          hist[i] <= hist[i-1];
        if (misalign)
          epc <= hist[0];
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit (DEPTH=3) with hand-computed expectations.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_imm16;
  logic        jmp;
  logic [25:0] jmp_target26;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [2:0]  hist_vec_valid;
  logic [31:0] hist_pc;
  logic [31:0] link_pc;
  logic [31:0] epc;
  logic        exc;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit #(
    .WIDTH(32), .RESET_PC(32'h0040001c), .EXC_VECTOR(32'h80000180), .DEPTH(3)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_imm16(br_imm16), .jmp(jmp), .jmp_target26(jmp_target26), .jr(jr),
    .jr_addr(jr_addr), .pc(pc), .hist_vec_valid(hist_vec_valid),
    .hist_pc(hist_pc), .link_pc(link_pc), .epc(epc), .exc(exc)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one active (falling) edge and settle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; jmp = 0; jr = 0;
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog got=%0d exp=%0d", 0, 1);
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; idle();
    br_imm16 = 16'h0; jmp_target26 = 26'h0; jr_addr = 32'h0;
    tick();
    chk("rst_pc",    pc, 32'h0040001c);
    chk("rst_vld",   {29'h0, hist_vec_valid}, 32'h0);
    chk("rst_hist",  hist_pc, 32'h0);
    chk("rst_epc",   epc, 32'h0);
    chk("rst_exc",   {31'h0, exc}, 32'h0);
    reset = 0;

    // Sequential steps
    tick(); chk("seq1_pc", pc, 32'h00400020); chk("seq1_vld", {29'h0, hist_vec_valid}, 32'h1);
    tick(); chk("seq2_pc", pc, 32'h00400024);
    tick(); chk("seq3_pc", pc, 32'h00400028);
    chk("seq3_hpc", hist_pc, 32'h0040001c); chk("seq3_vld", {29'h0, hist_vec_valid}, 32'h7);
    tick(); chk("seq4_pc", pc, 32'h0040002c); chk("seq4_hpc", hist_pc, 32'h00400020);

    // Stall holds state and ignores requests
    stall = 1; br_taken = 1; jmp = 1; br_imm16 = 16'hFFFE; jmp_target26 = 26'h0100010;
    tick(); tick();
    chk("stl_pc",   pc, 32'h0040002c);
    chk("stl_hpc",  hist_pc, 32'h00400020);
    chk("stl_vld",  {29'h0, hist_vec_valid}, 32'h7);
    chk("stl_link", link_pc, 32'h0040002c);
    chk("stl_epc",  epc, 32'h0);
    chk("stl_exc",  {31'h0, exc}, 32'h0);

    // Backward branch squashes everything, repeat is ignored
    stall = 0; jmp = 0; br_taken = 1;
    tick(); chk("br_pc", pc, 32'h0040001c); chk("br_vld", {29'h0, hist_vec_valid}, 32'h0);
    tick(); chk("br_rep_pc", pc, 32'h00400020); chk("br_rep_vld", {29'h0, hist_vec_valid}, 32'h1);

    // Absolute jump
    idle();
    tick(); tick();
    chk("pre_j_link", link_pc, 32'h00400028);
    jmp = 1; jmp_target26 = 26'h0100010;
    tick();
    chk("j_pc", pc, 32'h00400040);
    chk("j_vld", {29'h0, hist_vec_valid}, 32'h6);
    chk("j_hpc", hist_pc, 32'h00400020);
    jmp = 0;
    tick(); chk("j_nxt_vld", {29'h0, hist_vec_valid}, 32'h5);

    // Branch beats jump on the same edge
    jmp = 1; br_taken = 1; br_imm16 = 16'h0004;
    tick();
    chk("bj_pc", pc, 32'h00400038);
    chk("bj_vld", {29'h0, hist_vec_valid}, 32'h0);
    idle();

    // Misaligned jr raises exception, stall clears exc
    tick();
    jr = 1; jr_addr = 32'h00400002;
    tick();
    chk("jrx_pc",  pc, 32'h80000180);
    chk("jrx_epc", epc, 32'h00400038);
    chk("jrx_exc", {31'h0, exc}, 32'h1);
    jr = 0; stall = 1;
    tick();
    chk("jrx_exc_clr", {31'h0, exc}, 32'h0);
    chk("jrx_stl_pc", pc, 32'h80000180);
    stall = 0;
    tick(); chk("jrx_seq_pc", pc, 32'h80000184);

    // Aligned jr wins over jmp
    jr = 1; jr_addr = 32'h00400100; jmp = 1; jmp_target26 = 26'h0100010;
    tick();
    chk("jr_pc",  pc, 32'h00400100);
    chk("jr_exc", {31'h0, exc}, 32'h0);
    chk("jr_epc", epc, 32'h00400038);
    chk("jr_vld", {29'h0, hist_vec_valid}, 32'h2);

    // jr from a squashed slot is ignored
    jmp = 0; jr_addr = 32'h00400200;
    tick(); chk("jr_sq_pc", pc, 32'h00400104);
    idle();

    // Asynchronous reset between edges
    #2 reset = 1;
    #1;
    chk("arst_pc",  pc, 32'h0040001c);
    chk("arst_vld", {29'h0, hist_vec_valid}, 32'h0);
    chk("arst_epc", epc, 32'h0);
    reset = 0;
    tick();
    chk("arst_seq_pc", pc, 32'h00400020);
    chk("arst_seq_vld", {29'h0, hist_vec_valid}, 32'h1);

    // Wrap-around past all-ones
    jr = 1; jr_addr = 32'hFFFFFFFC;
    tick(); chk("wrap_set_pc", pc, 32'hFFFFFFFC);
    idle();
    tick();
    chk("wrap_pc", pc, 32'h00000000);
    chk("wrap_link", link_pc, 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
